exp_arbiter: RTL and testbench
==============================

EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters; FP_WIDTH, default 16, operand width; FP_EXP_WIDTH, default 8, exponent field width; FP_MAN_WIDTH, default 7, mantissa field width; TIMEOUT, default 64, WAIT cycles before error.
REQ-002 Ports SHALL be, in order: clk in 1, sole clock; reset_n in 1, asynchronous active-low reset.
REQ-003 req_data in NUM_REQ*FP_WIDTH, packed operands, requester i at slice [i*FP_WIDTH +: FP_WIDTH]; req_valid in NUM_REQ; req_ready out NUM_REQ.
REQ-004 rsp_data out FP_WIDTH, result shared by all requesters; rsp_valid out NUM_REQ, one-hot; rsp_ready in NUM_REQ.
REQ-005 eng_in_data out FP_WIDTH; eng_in_valid out 1; eng_in_ready in 1; eng_out_data in FP_WIDTH; eng_out_valid in 1; eng_out_ready out 1.
REQ-006 busy out 1, high in any state except IDLE; grant_id out clog2(NUM_REQ), current owner; timeout_err out 1, sticky error flag.

Function
REQ-010 The arbiter SHALL share one exp engine among NUM_REQ requesters, with at most one operation outstanding.
REQ-011 States SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-012 IDLE: if any req_valid is high, the arbiter SHALL pick winner w round-robin, searching from rr_ptr upward with wrap. It SHALL assert req_ready[w] combinationally that cycle only, latch op_q and id_q, and go to ISSUE.
REQ-013 req_ready SHALL be all-zero outside IDLE and zero for non-winners.
REQ-014 ISSUE: eng_in_valid SHALL be 1. On eng_in_ready=1 the arbiter SHALL go to WAIT; otherwise it SHALL hold in ISSUE.
REQ-015 eng_in_data SHALL equal op_q in ISSUE, WAIT and RESP. The engine samples its input combinationally over several cycles, so this operand SHALL stay stable until RESP exits.
REQ-016 WAIT: eng_out_ready SHALL be 1. On eng_out_valid=1 the arbiter SHALL latch eng_out_data into res_q and go to RESP.
REQ-017 eng_out_ready SHALL be 0 in every other state.
REQ-018 RESP: rsp_valid[id_q] SHALL be 1 and rsp_data SHALL be res_q. On rsp_ready[id_q]=1 the arbiter SHALL set rsp_ptr... SHALL set rr_ptr to id_q+1 modulo NUM_REQ and go to IDLE. Otherwise it SHALL hold.
REQ-019 rsp_data SHALL be 0 outside RESP.
REQ-020 Latency: rsp_valid SHALL rise exactly one cycle after the eng_out_valid handshake.
REQ-021 Throughput: the arbiter SHALL return to IDLE in the cycle after the rsp handshake.
REQ-022 A WAIT cycle counter SHALL clear on WAIT entry. If it reaches TIMEOUT, timeout_err SHALL set, the arbiter SHALL return res_q=0 to the requester via RESP, and timeout_err SHALL stay set until reset.
REQ-023 Dropping req_valid before acceptance SHALL have no effect. Dropping rsp_ready SHALL hold RESP indefinitely with data stable.
REQ-024 With all req_valid constantly high, grants SHALL cycle 0,1,2,...,NUM_REQ-1,0 with no requester starved.
REQ-025 The arbiter SHALL NOT inspect or alter operand or result values; special cases such as large-negative-to-zero belong to the engine.

Reset
REQ-030 Assertion of reset_n low SHALL immediately force state to IDLE and rr_ptr, op_q, id_q, res_q, the WAIT counter and timeout_err to 0, regardless of state.
REQ-031 All outputs SHALL read 0 during reset: req_ready, rsp_valid, eng_in_valid, eng_out_ready, busy, grant_id, rsp_data.
REQ-032 The engine SHALL share reset_n. An operation in flight at reset SHALL be discarded with no response.

Structure
REQ-040 Package exp_arb_pkg SHALL hold the state enum encoding, the default parameter values, and the bf16 constants used by the bench (ONE=16'h3F80, ZERO=16'h0000).
REQ-041 A single combinational sub-module rr_arbiter SHALL take (req vector, rr_ptr) and produce (one-hot grant, grant index, any_req).
REQ-042 The exp engine SHALL be instantiated outside this block, at the top level.

Verification
REQ-050 Single request: req 2 with 16'h0000 -> one rsp_valid[2] pulse with rsp_data=16'h3F80, no other rsp_valid bit, 1 cycle after the engine output handshake.
REQ-051 All four requesters valid continuously with distinct operands -> grants 0,1,2,3,0,...; each rsp_data matches the engine model for that requester's operand.
REQ-052 Req 1 with 16'hC2F0 (large negative) -> rsp_data=16'h0000 routed to requester 1 only.
REQ-053 rsp_ready[0] held low 20 cycles in RESP -> rsp_valid[0] and rsp_data stable; req_ready all 0; no new engine issue.
REQ-054 Engine stub withholds eng_out_valid for 64 cycles -> timeout_err=1, rsp_data=0 to the owner, return to IDLE, flag stays set.
REQ-055 reset_n pulsed low during WAIT -> all outputs 0 that cycle; after release, a new req 3 of 16'h3F80 completes normally.

Source files
------------

// File: rtl/exp_arb_pkg.sv
// Shared definitions for the exp engine arbiter: FSM encoding, default
// parameter values and the bf16 constants used around the engine.
package exp_arb_pkg;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_FP_WIDTH     = 16;
  localparam int unsigned DEF_FP_EXP_WIDTH = 8;
  localparam int unsigned DEF_FP_MAN_WIDTH = 7;
  localparam int unsigned DEF_TIMEOUT      = 64;

  localparam logic [15:0] ONE  = 16'h3F80;
  localparam logic [15:0] ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/exp_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above
// ptr_i, wrapping around to index 0.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int unsigned IW = $clog2(N);

  int unsigned   cand;
  logic [IW-1:0] c;
  logic          found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    c       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      c = IW'(cand);
      if (!found && req_i[c]) begin
        found      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = c;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/exp_arbiter.sv
// Shares one exp engine among NUM_REQ requesters, one operation in flight,
// with round-robin fairness and a sticky WAIT timeout.
module exp_arbiter
  import exp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned FP_WIDTH     = DEF_FP_WIDTH,
  parameter int unsigned FP_EXP_WIDTH = DEF_FP_EXP_WIDTH,
  parameter int unsigned FP_MAN_WIDTH = DEF_FP_MAN_WIDTH,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ*FP_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [FP_WIDTH-1:0]          rsp_data,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [FP_WIDTH-1:0]          eng_in_data,
  output logic                         eng_in_valid,
  input  logic                         eng_in_ready,
  input  logic [FP_WIDTH-1:0]          eng_out_data,
  input  logic                         eng_out_valid,
  output logic                         eng_out_ready,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  if (1 + FP_EXP_WIDTH + FP_MAN_WIDTH != FP_WIDTH) begin : g_fp_format_check
    $error("exp_arbiter: FP_WIDTH must equal 1 + FP_EXP_WIDTH + FP_MAN_WIDTH");
  end

  arb_state_e           state_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [IW-1:0]        id_q;
  logic [FP_WIDTH-1:0]  op_q;
  logic [FP_WIDTH-1:0]  res_q;
  logic [CW-1:0]        wait_cnt_q;
  logic                 err_q;
  logic                 busy_q;
  logic                 in_valid_q;
  logic                 out_ready_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;

  logic [NUM_REQ-1:0]   win_onehot;
  logic [IW-1:0]        win_idx;
  logic                 any_req;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (win_onehot),
    .idx_o   (win_idx),
    .any_o   (any_req)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_q        <= '0;
      res_q       <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      out_ready_q <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            op_q       <= req_data[win_idx*FP_WIDTH +: FP_WIDTH];
            id_q       <= win_idx;
            busy_q     <= 1'b1;
            in_valid_q <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (eng_in_ready) begin
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b1;
            wait_cnt_q  <= '0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real engine result wins over a timeout landing in the same cycle.
          if (eng_out_valid || wait_cnt_q == CW'(TIMEOUT - 1)) begin
            res_q       <= eng_out_valid ? eng_out_data : '0;
            err_q       <= err_q | ~eng_out_valid;
            out_ready_q <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << id_q;
            state_q     <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[id_q]) begin
            rr_ptr_q    <= (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Acceptance is combinational, so it is also masked while reset is held.
  assign req_ready     = (state_q == ST_IDLE && reset_n) ? win_onehot : '0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = (state_q == ST_RESP) ? res_q : '0;
  assign eng_in_data   = op_q;
  assign eng_in_valid  = in_valid_q;
  assign eng_out_ready = out_ready_q;
  assign busy          = busy_q;
  assign grant_id      = id_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_exp_arbiter.sv
// Self-checking bench for exp_arbiter: engine stub, transaction-level model
// compared every cycle, directed scenarios and a randomized soak.
module tb_exp_arbiter;
  import exp_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [N*W-1:0]     req_data = '0;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       req_ready;
  logic [W-1:0]       rsp_data;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready = '0;
  logic [W-1:0]       eng_in_data;
  logic               eng_in_valid;
  logic               eng_in_ready;
  logic [W-1:0]       eng_out_data;
  logic               eng_out_valid;
  logic               eng_out_ready;
  logic               busy;
  logic [1:0]         grant_id;
  logic               timeout_err;

  always #5 clk = ~clk;

  exp_arbiter #(
    .NUM_REQ(N), .FP_WIDTH(W), .FP_EXP_WIDTH(8), .FP_MAN_WIDTH(7), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .eng_in_data(eng_in_data), .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready),
    .eng_out_data(eng_out_data), .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine behaviour: exp(+-0)=1, exp(1)=e, exp(x<=-64)=0, otherwise an arbitrary stand-in.
  function automatic logic [15:0] eng_fn(input logic [15:0] x);
    if (x[14:0] == 15'd0) return ONE;
    if (x == ONE) return 16'h402E;
    if (x[15] && x[14:7] >= 8'h85) return ZERO;
    return x ^ 16'h5A5A;
  endfunction

  // ---------------- engine stub ----------------
  logic        e_busy, e_out, e_rdy, e_seen;
  logic [15:0] e_res;
  int          e_lat;
  bit          hang = 0;

  assign eng_in_ready  = e_rdy && !e_busy;
  assign eng_out_valid = e_out;
  assign eng_out_data  = e_res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_busy <= 0; e_out <= 0; e_rdy <= 0; e_seen <= 0; e_lat <= 0; e_res <= '0;
    end else begin
      e_rdy <= ($urandom_range(3) != 0);
      if (!e_busy) begin
        if (eng_in_valid && eng_in_ready) begin
          e_busy <= 1; e_seen <= 0; e_lat <= int'($urandom_range(4));
        end
      end else if (e_out) begin
        if (eng_out_ready) begin e_out <= 0; e_busy <= 0; end
      end else if (hang) begin
        if (eng_out_ready) e_seen <= 1;
        else if (e_seen) e_busy <= 0;
      end else if (e_lat == 0) begin
        e_out <= 1;
        e_res <= eng_fn(eng_in_data);   // operand read late: must still be held stable
      end else begin
        e_lat <= e_lat - 1;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  int          m_owner = -1, m_last = 0, m_rr = 0, m_wait = 0;
  bit          m_issued = 0, m_hasres = 0, m_err = 0;
  logic [15:0] m_op = '0, m_res = '0;
  int          done_id[$];
  logic [15:0] done_data[$];
  int          grant_log[$];

  int          w;
  logic [N-1:0] x_rr, x_rv;
  logic [15:0]  x_rd;
  logic         x_iv, x_or, x_busy, x_err;
  logic [1:0]   x_gid;

  always @(negedge clk) begin
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;

    if (!reset_n) begin
      x_rr = '0; x_rv = '0; x_rd = '0; x_iv = 0; x_or = 0; x_busy = 0; x_gid = 0; x_err = 0;
    end else begin
      x_busy = (m_owner >= 0);
      x_rr   = (m_owner < 0 && w >= 0) ? N'(1) << w : '0;
      x_iv   = (m_owner >= 0) && !m_issued;
      x_or   = m_issued && !m_hasres;
      x_rv   = m_hasres ? N'(1) << m_owner : '0;
      x_rd   = m_hasres ? m_res : '0;
      x_gid  = 2'(m_last);
      x_err  = m_err;
    end

    chk("req_ready", 32'(req_ready), 32'(x_rr));
    chk("rsp_valid", 32'(rsp_valid), 32'(x_rv));
    chk("rsp_data", 32'(rsp_data), 32'(x_rd));
    chk("eng_in_valid", 32'(eng_in_valid), 32'(x_iv));
    chk("eng_out_ready", 32'(eng_out_ready), 32'(x_or));
    chk("busy", 32'(busy), 32'(x_busy));
    chk("grant_id", 32'(grant_id), 32'(x_gid));
    chk("timeout_err", 32'(timeout_err), 32'(x_err));
    if (reset_n && m_owner >= 0) chk("eng_in_data", 32'(eng_in_data), 32'(m_op));

    if (!reset_n) begin
      m_owner = -1; m_last = 0; m_rr = 0; m_wait = 0;
      m_issued = 0; m_hasres = 0; m_err = 0; m_op = '0; m_res = '0;
    end else if (m_owner < 0) begin
      if (w >= 0) begin
        m_owner = w; m_last = w; m_op = req_data[w*W +: W]; grant_log.push_back(w);
      end
    end else if (!m_issued) begin
      if (eng_in_ready) begin m_issued = 1; m_wait = 0; end
    end else if (!m_hasres) begin
      if (eng_out_valid) begin
        m_hasres = 1; m_res = eng_out_data;
      end else begin
        m_wait++;
        if (m_wait == TO) begin m_err = 1; m_hasres = 1; m_res = '0; end
      end
    end else if (rsp_ready[m_owner]) begin
      done_id.push_back(m_owner); done_data.push_back(m_res);
      m_rr = (m_owner + 1) % N;
      m_owner = -1; m_issued = 0; m_hasres = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int id, input logic [15:0] op, input int budget);
    int  n0;
    bit  got;
    n0 = done_id.size();
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_data[id*W +: W] = op;
    got = 0;
    for (int c = 0; c < budget && !got; c++) begin tick(); if (m_owner == id) got = 1; end
    req_valid = '0;
    chk("accept_wait", 32'(got), 32'd1);
    got = 0;
    for (int c = 0; c < budget && !got; c++) begin tick(); if (done_id.size() > n0) got = 1; end
    chk("response_wait", 32'(got), 32'd1);
  endtask

  task automatic chk_last(input string name, input int id, input logic [15:0] data);
    if (done_id.size() == 0) begin
      chk({name, "_present"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_id"}, 32'(done_id[$]), 32'(id));
      chk({name, "_data"}, 32'(done_data[$]), 32'(data));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n0, g0;
    bit got;
    logic [15:0] ops[4];
    logic [15:0] exps[4];
    ops  = '{16'h0000, 16'h3F80, 16'hC2F0, 16'h4000};
    exps = '{16'h3F80, 16'h402E, 16'h0000, 16'h1A5A};

    // reset state, with requests pending to show req_ready stays low
    #1 reset_n = 0;
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_eng_in_valid", 32'(eng_in_valid), 32'd0);
    req_valid = '0;
    rsp_ready = '1;
    reset_n = 1;
    tick();

    // single request from 2
    do_req(2, 16'h0000, 100);
    chk_last("single", 2, 16'h3F80);

    // all requesters continuously valid, fresh round-robin pointer
    reset_n = 0; tick(); tick(); reset_n = 1; tick();
    n0 = done_id.size(); g0 = grant_log.size();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = ops[i];
    req_valid = '1;
    got = 0;
    for (int c = 0; c < 400 && !got; c++) begin tick(); if (done_id.size() >= n0 + 8) got = 1; end
    req_valid = '0;
    chk("rr_wait", 32'(got), 32'd1);
    for (int c = 0; c < 100 && m_owner >= 0; c++) tick();
    if (got) begin
      for (int k = 0; k < 8; k++) begin
        chk("rr_grant", 32'(grant_log[g0 + k]), 32'(k % N));
        chk("rr_done_id", 32'(done_id[n0 + k]), 32'(k % N));
        chk("rr_done_data", 32'(done_data[n0 + k]), 32'(exps[k % N]));
      end
    end

    // large negative operand routed back to requester 1
    do_req(1, 16'hC2F0, 100);
    chk_last("largeneg", 1, 16'h0000);

    // response back-pressure on requester 0
    rsp_ready = 4'b1110;
    req_valid = 4'b0001; req_data[0 +: W] = 16'h3F80;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin tick(); if (m_owner == 0) got = 1; end
    req_valid = '0;
    chk("hold_accept", 32'(got), 32'd1);
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin tick(); if (m_hasres) got = 1; end
    chk("hold_resp", 32'(got), 32'd1);
    req_valid = 4'b1110;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", 32'(rsp_data), 32'h402E);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_eng_in_valid", 32'(eng_in_valid), 32'd0);
    end
    req_valid = '0; rsp_ready = '1;
    n0 = done_id.size();
    for (int c = 0; c < 10 && done_id.size() == n0; c++) tick();
    chk_last("hold_release", 0, 16'h402E);

    // engine never answers: timeout
    hang = 1;
    do_req(3, 16'h3F80, 200);
    chk_last("timeout", 3, 16'h0000);
    chk("timeout_flag", 32'(timeout_err), 32'd1);
    hang = 0;
    tick(); tick();
    do_req(1, 16'h0000, 100);
    chk_last("after_timeout", 1, 16'h3F80);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // reset while an operation is in WAIT
    hang = 1;
    req_valid = 4'b0100; req_data[2*W +: W] = 16'h1234;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin tick(); if (m_owner == 2) got = 1; end
    req_valid = '0;
    for (int c = 0; c < 50 && !m_issued; c++) tick();
    tick(); tick(); tick();
    n0 = done_id.size();
    reset_n = 0; req_valid = '1;
    #1;
    chk("wrst_req_ready", 32'(req_ready), 32'd0);
    chk("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wrst_eng_in_valid", 32'(eng_in_valid), 32'd0);
    chk("wrst_eng_out_ready", 32'(eng_out_ready), 32'd0);
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_grant_id", 32'(grant_id), 32'd0);
    chk("wrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("wrst_timeout_err", 32'(timeout_err), 32'd0);
    tick(); tick();
    req_valid = '0; hang = 0; reset_n = 1;
    tick(); tick();
    chk("wrst_no_response", 32'(done_id.size()), 32'(n0));
    do_req(3, 16'h3F80, 100);
    chk_last("post_reset", 3, 16'h402E);
    chk("post_reset_count", 32'(done_id.size()), 32'(n0 + 1));

    // randomized soak
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(7))
          0:       req_data[i*W +: W] = 16'h0000;
          1:       req_data[i*W +: W] = 16'h3F80;
          2:       req_data[i*W +: W] = 16'hC2F0;
          default: req_data[i*W +: W] = 16'($urandom);
        endcase
        rsp_ready[i] = ($urandom_range(3) != 0);
      end
      tick();
    end
    req_valid = '0; rsp_ready = '1;
    for (int c = 0; c < 100 && m_owner >= 0; c++) tick();
    chk("drain_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
